// File: rtl/regfile_wb_arbiter_if.sv
// Register-file writeback bus: pipeline writeback, MUL/DIV result handshake,
// MUL/DIV issue notification, register-file write port and busy scoreboard.
// The slave modport is the arbiter; the master modport is its surroundings.
interface regfile_wb_arbiter_if #(
    parameter int REGISTER_FILE_SIZE = 32
);
    logic                          pipe_wb_en;
    logic [4:0]                    pipe_wb_id;
    logic [31:0]                   pipe_wb_data;
    logic                          pipe_stall;

    logic                          md_valid;
    logic                          md_ready;
    logic [4:0]                    md_id;
    logic [31:0]                   md_data;

    logic                          md_issue_en;
    logic [4:0]                    md_issue_id;

    logic                          rf_write_en;
    logic [4:0]                    rf_write_id;
    logic [31:0]                   rf_write_data;

    logic [REGISTER_FILE_SIZE-1:0] busy_mask;

    modport slave (
        input  pipe_wb_en, pipe_wb_id, pipe_wb_data,
        input  md_valid, md_id, md_data,
        input  md_issue_en, md_issue_id,
        output pipe_stall, md_ready,
        output rf_write_en, rf_write_id, rf_write_data,
        output busy_mask
    );

    modport master (
        output pipe_wb_en, pipe_wb_id, pipe_wb_data,
        output md_valid, md_id, md_data,
        output md_issue_en, md_issue_id,
        input  pipe_stall, md_ready,
        input  rf_write_en, rf_write_id, rf_write_data,
        input  busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole driver of the integer register file write port.
// Pipeline writeback has priority; MUL/DIV results wait in a small FIFO and a
// starvation counter forces a drain after STARVE_LIMIT blocked cycles. A busy
// scoreboard tracks registers still waiting on a MUL/DIV result.
// Optional feature macro WB_BYPASS_EN: when the FIFO is empty and the pipeline
// is idle, a valid MUL/DIV result is written straight through in the same cycle.
module regfile_wb_arbiter #(
    parameter int FIFO_DEPTH         = 2,
    parameter int STARVE_LIMIT       = 4,
    parameter int REGISTER_FILE_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_e;

    logic [4:0]                    fifo_id   [FIFO_DEPTH];
    logic [31:0]                   fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              fifo_count;
    logic [STARVE_W-1:0]           starve_cnt;
    logic [REGISTER_FILE_SIZE-1:0] busy_q;
    logic [REGISTER_FILE_SIZE-1:0] busy_next;

    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          push;
    logic                          pop;
    logic                          md_retire;
    logic                          stall;
    wb_src_e                       src;
    logic [4:0]                    grant_id;
    logic [31:0]                   grant_data;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Pick this cycle's writer: pipeline first, unless it has starved the FIFO long enough.
    always_comb begin
        src   = SRC_NONE;
        stall = 1'b0;
        if (!reset) begin
            if (bus.pipe_wb_en) begin
                if ((starve_cnt == STARVE_W'(STARVE_LIMIT)) && !fifo_empty) begin
                    src   = SRC_FIFO;
                    stall = 1'b1;
                end else begin
                    src = SRC_PIPE;
                end
            end else if (!fifo_empty) begin
                src = SRC_FIFO;
            end
`ifdef WB_BYPASS_EN
            else if (bus.md_valid) begin
                src = SRC_BYPASS;
            end
`endif
        end
    end

    // Route the granted source onto the write port; idle drives zeros.
    always_comb begin
        grant_id   = 5'd0;
        grant_data = 32'd0;
        case (src)
            SRC_PIPE: begin
                grant_id   = bus.pipe_wb_id;
                grant_data = bus.pipe_wb_data;
            end
            SRC_FIFO: begin
                grant_id   = fifo_id[rd_ptr];
                grant_data = fifo_data[rd_ptr];
            end
            SRC_BYPASS: begin
                grant_id   = bus.md_id;
                grant_data = bus.md_data;
            end
            default: begin
                grant_id   = 5'd0;
                grant_data = 32'd0;
            end
        endcase
    end

    assign pop       = (src == SRC_FIFO);
    assign md_retire = (src == SRC_FIFO) || (src == SRC_BYPASS);
    assign push      = !reset && bus.md_valid && !fifo_full && (src != SRC_BYPASS);

    assign bus.rf_write_en   = (src != SRC_NONE) && (grant_id != 5'd0);
    assign bus.rf_write_id   = grant_id;
    assign bus.rf_write_data = grant_data;
    assign bus.pipe_stall    = stall;
    assign bus.md_ready      = reset || !fifo_full;
    assign bus.busy_mask     = busy_q;

    // Next scoreboard: a retiring MUL/DIV result clears its bit, a new issue sets it (set wins).
    always_comb begin
        busy_next = busy_q;
        if (md_retire) begin
            busy_next[grant_id] = 1'b0;
        end
        if (bus.md_issue_en && (bus.md_issue_id != 5'd0)) begin
            busy_next[bus.md_issue_id] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Result storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= bus.md_id;
            fifo_data[wr_ptr] <= bus.md_data;
        end
    end

    // Pointers, occupancy, starvation counter and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            busy_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (src == SRC_FIFO) begin
                starve_cnt <= '0;
            end else if ((src == SRC_PIPE) && !fifo_empty) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            busy_q <= busy_next;
        end
    end

    // Decode must not issue to a busy register unless that register's result retires this cycle.
    assert property (@(posedge clk) disable iff (reset)
        !(bus.md_issue_en && busy_q[bus.md_issue_id] &&
          !(md_retire && (grant_id == bus.md_issue_id))));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a queue-based reference model checks every
// output on every falling edge, while directed sequences pin literal values.
// Build with or without WB_BYPASS_EN; expectations follow the macro.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
    } md_entry_t;

    md_entry_t   model_q[$];
    int          model_starve = 0;
    logic [31:0] model_busy = '0;

    regfile_wb_arbiter_if #(.REGISTER_FILE_SIZE(32)) bus ();

    regfile_wb_arbiter #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .REGISTER_FILE_SIZE(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pwe, input logic [4:0] pid, input logic [31:0] pdata,
                                 input logic mv, input logic [4:0] mid, input logic [31:0] mdata,
                                 input logic ie, input logic [4:0] iid);
        @(posedge clk);
        #1;
        bus.pipe_wb_en   = pwe;
        bus.pipe_wb_id   = pid;
        bus.pipe_wb_data = pdata;
        bus.md_valid     = mv;
        bus.md_id        = mid;
        bus.md_data      = mdata;
        bus.md_issue_en  = ie;
        bus.md_issue_id  = iid;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Reference model: derive this cycle's outputs from the queue state, compare, then advance.
    always @(negedge clk) begin : model_compare
        logic        take_pipe;
        logic        take_fifo;
        logic        take_bypass;
        logic        accept;
        logic        exp_en;
        logic        exp_stall;
        logic        exp_ready;
        logic [4:0]  exp_id;
        logic [31:0] exp_data;
        md_entry_t   entry;

        checkOutput("model busy_mask", bus.busy_mask, model_busy);

        take_pipe   = 1'b0;
        take_fifo   = 1'b0;
        take_bypass = 1'b0;
        exp_stall   = 1'b0;
        exp_ready   = reset || (model_q.size() < FIFO_DEPTH);
        if (!reset) begin
            if (bus.pipe_wb_en) begin
                if (model_starve >= STARVE_LIMIT && model_q.size() != 0) begin
                    take_fifo = 1'b1;
                    exp_stall = 1'b1;
                end else begin
                    take_pipe = 1'b1;
                end
            end else if (model_q.size() != 0) begin
                take_fifo = 1'b1;
            end else if (BYPASS && bus.md_valid) begin
                take_bypass = 1'b1;
            end
        end

        exp_id   = 5'd0;
        exp_data = 32'd0;
        if (take_pipe) begin
            exp_id   = bus.pipe_wb_id;
            exp_data = bus.pipe_wb_data;
        end else if (take_fifo) begin
            exp_id   = model_q[0].id;
            exp_data = model_q[0].data;
        end else if (take_bypass) begin
            exp_id   = bus.md_id;
            exp_data = bus.md_data;
        end
        exp_en = (take_pipe || take_fifo || take_bypass) && (exp_id != 5'd0);

        checkOutput("model rf_write_en", {31'd0, bus.rf_write_en}, {31'd0, exp_en});
        checkOutput("model rf_write_id", {27'd0, bus.rf_write_id}, {27'd0, exp_id});
        if (exp_en || !(take_pipe || take_fifo || take_bypass)) begin
            checkOutput("model rf_write_data", bus.rf_write_data, exp_data);
        end
        checkOutput("model pipe_stall", {31'd0, bus.pipe_stall}, {31'd0, exp_stall});
        checkOutput("model md_ready", {31'd0, bus.md_ready}, {31'd0, exp_ready});

        if (reset) begin
            model_q.delete();
            model_starve = 0;
            model_busy   = '0;
        end else begin
            accept = bus.md_valid && (model_q.size() < FIFO_DEPTH) && !take_bypass;
            if (take_fifo) begin
                model_busy[model_q[0].id] = 1'b0;
                entry = model_q.pop_front();
                model_starve = 0;
            end else if (take_pipe && model_q.size() != 0) begin
                model_starve++;
            end
            if (take_bypass) begin
                model_busy[bus.md_id] = 1'b0;
            end
            if (accept) begin
                entry.id   = bus.md_id;
                entry.data = bus.md_data;
                model_q.push_back(entry);
            end
            if (bus.md_issue_en && bus.md_issue_id != 5'd0) begin
                model_busy[bus.md_issue_id] = 1'b1;
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences with hand-computed expectations.
    initial begin
        bus.pipe_wb_en   = 1'b0;
        bus.pipe_wb_id   = 5'd0;
        bus.pipe_wb_data = 32'd0;
        bus.md_valid     = 1'b1;
        bus.md_id        = 5'd3;
        bus.md_data      = 32'h0BAD_0BAD;
        bus.md_issue_en  = 1'b0;
        bus.md_issue_id  = 5'd0;
        reset            = 1'b1;

        // Reset held with a valid MUL/DIV result presented.
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset rf_write_en", {31'd0, bus.rf_write_en}, 32'd0);
            checkOutput("reset rf_write_id", {27'd0, bus.rf_write_id}, 32'd0);
            checkOutput("reset rf_write_data", bus.rf_write_data, 32'd0);
            checkOutput("reset pipe_stall", {31'd0, bus.pipe_stall}, 32'd0);
            checkOutput("reset md_ready", {31'd0, bus.md_ready}, 32'd1);
            checkOutput("reset busy_mask", bus.busy_mask, 32'd0);
        end
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.md_valid = 1'b0;
        @(negedge clk);
        checkOutput("post-reset no push", {31'd0, bus.rf_write_en}, 32'd0);
        checkOutput("post-reset md_ready", {31'd0, bus.md_ready}, 32'd1);

        // Single MUL/DIV result to x5 with an idle pipeline.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
        checkOutput("x5 busy set", {31'd0, bus.busy_mask[5]}, 32'd1);
        if (BYPASS) begin
            checkOutput("x5 bypass write_en", {31'd0, bus.rf_write_en}, 32'd1);
            checkOutput("x5 bypass write_data", bus.rf_write_data, 32'hDEAD_BEEF);
        end else begin
            checkOutput("x5 accept cycle write_en", {31'd0, bus.rf_write_en}, 32'd0);
        end
        idleCycle();
        if (BYPASS) begin
            checkOutput("x5 busy cleared", {31'd0, bus.busy_mask[5]}, 32'd0);
        end else begin
            checkOutput("x5 fifo write_en", {31'd0, bus.rf_write_en}, 32'd1);
            checkOutput("x5 fifo write_id", {27'd0, bus.rf_write_id}, 32'd5);
            checkOutput("x5 fifo write_data", bus.rf_write_data, 32'hDEAD_BEEF);
            checkOutput("x5 busy still set", {31'd0, bus.busy_mask[5]}, 32'd1);
        end
        idleCycle();
        checkOutput("x5 busy final", {31'd0, bus.busy_mask[5]}, 32'd0);

        // Starvation: x7 waits while the pipeline writes every cycle.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        applyStimulus(1'b1, 5'd10, 32'hA000_000A, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0);
        checkOutput("starve push-cycle write_id", {27'd0, bus.rf_write_id}, 32'd10);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'(11 + k), 32'hA000_0000 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            checkOutput("starve pipe grant id", {27'd0, bus.rf_write_id}, 32'(11 + k));
            checkOutput("starve pipe grant stall", {31'd0, bus.pipe_stall}, 32'd0);
        end
        applyStimulus(1'b1, 5'd15, 32'hF0F0_0015, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("forced drain stall", {31'd0, bus.pipe_stall}, 32'd1);
        checkOutput("forced drain id", {27'd0, bus.rf_write_id}, 32'd7);
        checkOutput("forced drain data", bus.rf_write_data, 32'h0000_0077);
        applyStimulus(1'b1, 5'd15, 32'hF0F0_0015, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        checkOutput("re-presented stall", {31'd0, bus.pipe_stall}, 32'd0);
        checkOutput("re-presented id", {27'd0, bus.rf_write_id}, 32'd15);
        checkOutput("re-presented data", bus.rf_write_data, 32'hF0F0_0015);
        checkOutput("x7 busy cleared", {31'd0, bus.busy_mask[7]}, 32'd0);
        idleCycle();

        // Fill the FIFO behind a busy pipeline; the third result must wait for a pop.
        applyStimulus(1'b1, 5'd16, 32'h1616_1616, 1'b1, 5'd20, 32'h2020_2020, 1'b0, 5'd0);
        checkOutput("fill 1 md_ready", {31'd0, bus.md_ready}, 32'd1);
        applyStimulus(1'b1, 5'd17, 32'h1717_1717, 1'b1, 5'd21, 32'h2121_2121, 1'b0, 5'd0);
        checkOutput("fill 2 md_ready", {31'd0, bus.md_ready}, 32'd1);
        applyStimulus(1'b1, 5'd18, 32'h1818_1818, 1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0);
        checkOutput("full md_ready", {31'd0, bus.md_ready}, 32'd0);
        applyStimulus(1'b1, 5'd19, 32'h1919_1919, 1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0);
        checkOutput("full held md_ready", {31'd0, bus.md_ready}, 32'd0);
        applyStimulus(1'b1, 5'd24, 32'h2424_2424, 1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0);
        checkOutput("full held 2 md_ready", {31'd0, bus.md_ready}, 32'd0);
        applyStimulus(1'b1, 5'd25, 32'h2525_2525, 1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0);
        checkOutput("drain pop stall", {31'd0, bus.pipe_stall}, 32'd1);
        checkOutput("drain pop id", {27'd0, bus.rf_write_id}, 32'd20);
        checkOutput("drain pop md_ready pre-pop", {31'd0, bus.md_ready}, 32'd0);
        applyStimulus(1'b1, 5'd25, 32'h2525_2525, 1'b1, 5'd22, 32'h2222_2222, 1'b0, 5'd0);
        checkOutput("after pop md_ready", {31'd0, bus.md_ready}, 32'd1);
        checkOutput("after pop write_id", {27'd0, bus.rf_write_id}, 32'd25);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'h2323_2323, 1'b0, 5'd0);
        checkOutput("full pop x21 md_ready", {31'd0, bus.md_ready}, 32'd0);
        checkOutput("full pop x21 data", bus.rf_write_data, 32'h2121_2121);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'h2323_2323, 1'b0, 5'd0);
        checkOutput("push+pop md_ready", {31'd0, bus.md_ready}, 32'd1);
        checkOutput("push+pop data", bus.rf_write_data, 32'h2222_2222);
        idleCycle();
        checkOutput("last entry id", {27'd0, bus.rf_write_id}, 32'd23);
        checkOutput("last entry data", bus.rf_write_data, 32'h2323_2323);
        idleCycle();
        checkOutput("fifo drained write_en", {31'd0, bus.rf_write_en}, 32'd0);

        // Result to x0, plus an issue to x0 that must not mark it busy.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0);
        checkOutput("x0 cycle1 write_en", {31'd0, bus.rf_write_en}, 32'd0);
        idleCycle();
        checkOutput("x0 cycle2 write_en", {31'd0, bus.rf_write_en}, 32'd0);
        checkOutput("x0 busy_mask", bus.busy_mask, 32'd0);
        idleCycle();
        checkOutput("x0 after busy_mask", bus.busy_mask, 32'd0);

        // Re-issue to x9 in the same cycle its earlier result is written: set wins.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        applyStimulus(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd9, 32'h9999_9999, 1'b0, 5'd0);
        checkOutput("x9 busy before", {31'd0, bus.busy_mask[9]}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        checkOutput("x9 fifo write_id", {27'd0, bus.rf_write_id}, 32'd9);
        checkOutput("x9 fifo write_data", bus.rf_write_data, 32'h9999_9999);
        idleCycle();
        checkOutput("x9 set wins", bus.busy_mask, 32'h0000_0200);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0);
        repeat (3) idleCycle();
        checkOutput("final busy_mask", bus.busy_mask, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
